// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator: accepts register commands on a valid/ready handshake and
// shifts each out as a {write, addr, data} frame, MSB first, on ncs/sclk/copi.
module spi_reg_writer #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              ncs,
    output logic              sclk,
    output logic              copi,
    output logic              busy,
    output logic              done
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = $clog2(CLK_DIV) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] BIT_NEXTI = BIT_W'(FRAME_W - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t               state_reg;
    logic [FRAME_W-1:0]   frame_reg;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic                 ready_reg;
    logic                 ncs_reg;
    logic                 sclk_reg;
    logic                 copi_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic                 div_wrap;

    assign div_wrap  = (div_cnt_reg == DIV_LAST);

    assign cmd_ready = ready_reg;
    assign ncs       = ncs_reg;
    assign sclk      = sclk_reg;
    assign copi      = copi_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            frame_reg   <= '0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            ready_reg   <= 1'b1;
            ncs_reg     <= 1'b1;
            sclk_reg    <= 1'b0;
            copi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        // MSB goes straight onto copi so it is valid for the whole first low half
                        frame_reg   <= {cmd_write, cmd_addr, cmd_data};
                        copi_reg    <= cmd_write;
                        state_reg   <= SHIFT;
                        ready_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        ncs_reg     <= 1'b0;
                        sclk_reg    <= 1'b0;
                        div_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    if (div_wrap) begin
                        div_cnt_reg <= '0;
                        if (!sclk_reg) begin
                            sclk_reg <= 1'b1;
                        end else begin
                            sclk_reg <= 1'b0;
                            if (bit_cnt_reg == BIT_LAST) begin
                                bit_cnt_reg <= '0;
                                state_reg   <= HOLD;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                                copi_reg    <= frame_reg[BIT_NEXTI - bit_cnt_reg];
                            end
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_wrap) begin
                        div_cnt_reg <= '0;
                        state_reg   <= GAP;
                        ncs_reg     <= 1'b1;
                        copi_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    // Guarantees ncs stays high for at least one full divider period
                    if (div_wrap) begin
                        div_cnt_reg <= '0;
                        state_reg   <= IDLE;
                        ready_reg   <= 1'b1;
                        busy_reg    <= 1'b0;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    ncs_reg   <= 1'b1;
                    sclk_reg  <= 1'b0;
                    copi_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: one instance at CLK_DIV=4, one at CLK_DIV=1,
// with a passive monitor capturing the bits seen on each sclk rising edge.
module tb_spi_reg_writer;

    logic       clk = 1'b0;
    logic       rst;

    logic       cmd_valid0, cmd_ready0, cmd_write0;
    logic [6:0] cmd_addr0;
    logic [7:0] cmd_data0;
    logic       ncs0, sclk0, copi0, busy0, done0;

    logic       cmd_valid1, cmd_ready1, cmd_write1;
    logic [6:0] cmd_addr1;
    logic [7:0] cmd_data1;
    logic       ncs1, sclk1, copi1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_reg_writer #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write0),
        .cmd_addr(cmd_addr0), .cmd_data(cmd_data0),
        .ncs(ncs0), .sclk(sclk0), .copi(copi0), .busy(busy0), .done(done0)
    );

    spi_reg_writer #(.CLK_DIV(1), .ADDR_W(7), .DATA_W(8)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write1),
        .cmd_addr(cmd_addr1), .cmd_data(cmd_data1),
        .ncs(ncs1), .sclk(sclk1), .copi(copi1), .busy(busy1), .done(done1)
    );

    // Peripheral-side view: shift copi on every sclk rise while selected
    logic        prev0 = 1'b0, prev1 = 1'b0;
    logic [15:0] cap0 = '0, cap1 = '0;
    int          rise0 = 0, rise1 = 0, dcnt0 = 0, dcnt1 = 0;

    always @(negedge clk) begin
        prev0 <= sclk0;
        prev1 <= sclk1;
        if (prev0 === 1'b0 && sclk0 === 1'b1 && ncs0 === 1'b0) begin
            cap0  <= {cap0[14:0], copi0};
            rise0 <= rise0 + 1;
        end
        if (prev1 === 1'b0 && sclk1 === 1'b1 && ncs1 === 1'b0) begin
            cap1  <= {cap1[14:0], copi1};
            rise1 <= rise1 + 1;
        end
        if (done0 === 1'b1) dcnt0 <= dcnt0 + 1;
        if (done1 === 1'b1) dcnt1 <= dcnt1 + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle0(input string name);
        int n;
        n = 0;
        while (cmd_ready0 !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: cmd_ready=%b after %0d cycles, required 1", name, cmd_ready0, n);
        end
    endtask

    // Presents one command and steps through the accept edge; returns at obs 0 of the frame
    task automatic accept0(input logic w, input logic [6:0] a, input logic [7:0] d);
        cmd_write0 = w;
        cmd_addr0  = a;
        cmd_data0  = d;
        cmd_valid0 = 1'b1;
        step();
        cmd_valid0 = 1'b0;
        cmd_addr0  = 7'h5A;
        cmd_data0  = 8'hC3;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ncs0 !== 1'b1 || sclk0 !== 1'b0 || copi0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_outputs: %0d bad cycles (ncs=%b sclk=%b copi=%b done=%b busy=%b), required ncs=1 others 0",
                     bad, ncs0, sclk0, copi0, done0, busy0);
        end
        rst = 1'b0;
        step();
        checks++;
        if (cmd_ready0 !== 1'b1 || cmd_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready0=%b cmd_ready1=%b, required 1", cmd_ready0, cmd_ready1);
        end
        $display("reset: released, cmd_ready0=%b", cmd_ready0);
    endtask

    task automatic test_write();
        int r0, d0, bad_ncs, bad_rdy, first_rise;
        logic prev, done_at, rdy_at;
        r0 = rise0; d0 = dcnt0;
        bad_ncs = 0; bad_rdy = 0; first_rise = -1; prev = 1'b0;
        done_at = 1'b0; rdy_at = 1'b0;
        accept0(1'b1, 7'h00, 8'hF0);
        for (int n = 0; n < 137; n++) begin
            if (n < 132 && ncs0 !== 1'b0) bad_ncs++;
            if (n >= 132 && ncs0 !== 1'b1) bad_ncs++;
            if (prev === 1'b0 && sclk0 === 1'b1 && first_rise < 0) first_rise = n;
            prev = sclk0;
            if (n == 132) done_at = done0;
            if (n == 136) rdy_at = cmd_ready0;
            else if (cmd_ready0 !== 1'b0) bad_rdy++;
            if (n < 136) step();
        end
        checks++;
        if (bad_ncs != 0) begin errors++; $display("FAIL write_ncs: %0d cycles wrong, required 0", bad_ncs); end
        checks++;
        if (first_rise != 4) begin errors++; $display("FAIL write_first_rise: at %0d, required 4", first_rise); end
        checks++;
        if (done_at !== 1'b1) begin errors++; $display("FAIL write_done_at: done=%b at T0+133, required 1", done_at); end
        checks++;
        if (rdy_at !== 1'b1 || bad_rdy != 0) begin
            errors++; $display("FAIL write_ready: ready=%b at T0+137, %0d early, required 1 and 0", rdy_at, bad_rdy);
        end
        checks++;
        if (cap0 !== 16'h80F0) begin errors++; $display("FAIL write_frame: got %h, required 80f0", cap0); end
        checks++;
        if (rise0 - r0 != 16 || dcnt0 - d0 != 1) begin
            errors++; $display("FAIL write_counts: rises=%0d dones=%0d, required 16 and 1", rise0 - r0, dcnt0 - d0);
        end
        $display("write: frame=%h rises=%0d first_rise=%0d", cap0, rise0 - r0, first_rise);
    endtask

    task automatic test_read();
        int cnt;
        cnt = 0;
        accept0(1'b0, 7'h04, 8'h55);
        while (busy0 === 1'b1 && cnt < 300) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt != 136) begin errors++; $display("FAIL read_busy: busy for %0d cycles, required 136", cnt); end
        checks++;
        if (cap0 !== 16'h0455) begin errors++; $display("FAIL read_frame: got %h, required 0455", cap0); end
        $display("read: frame=%h busy_cycles=%0d", cap0, cnt);
    endtask

    task automatic test_back_to_back();
        int d0, high_cnt, ready_obs;
        logic [15:0] first_frame;
        d0 = dcnt0; high_cnt = 0; ready_obs = -1; first_frame = '0;
        wait_idle0("b2b_start");
        cmd_write0 = 1'b1; cmd_addr0 = 7'h01; cmd_data0 = 8'hAA; cmd_valid0 = 1'b1;
        step();
        cmd_addr0 = 7'h02; cmd_data0 = 8'h55;
        for (int n = 0; n < 300; n++) begin
            if (ncs0 === 1'b1) high_cnt++;
            if (n == 132) first_frame = cap0;
            if (cmd_ready0 === 1'b1) begin
                ready_obs = n;
                break;
            end
            step();
        end
        step();
        cmd_valid0 = 1'b0;
        checks++;
        if (ready_obs != 136) begin errors++; $display("FAIL b2b_accept: second accept at T0+%0d, required T0+137", ready_obs + 1); end
        checks++;
        if (first_frame !== 16'h81AA) begin errors++; $display("FAIL b2b_frame1: got %h, required 81aa", first_frame); end
        checks++;
        if (high_cnt < 4 || ncs0 !== 1'b0) begin
            errors++; $display("FAIL b2b_gap: ncs high %0d cycles, ncs after accept=%b, required >=4 and 0", high_cnt, ncs0);
        end
        wait_idle0("b2b_end");
        checks++;
        if (cap0 !== 16'h8255) begin errors++; $display("FAIL b2b_frame2: got %h, required 8255", cap0); end
        checks++;
        if (dcnt0 - d0 != 2) begin errors++; $display("FAIL b2b_dones: %0d pulses, required 2", dcnt0 - d0); end
        $display("b2b: frame1=%h frame2=%h ncs_high=%0d", first_frame, cap0, high_cnt);
    endtask

    task automatic test_reset_mid_frame();
        int rises, n, d0;
        logic prev;
        rises = 0; n = 0; prev = 1'b0;
        wait_idle0("rstmid_start");
        accept0(1'b1, 7'h10, 8'h33);
        while (rises < 5 && n < 200) begin
            step();
            n++;
            if (prev === 1'b0 && sclk0 === 1'b1) rises++;
            prev = sclk0;
        end
        d0 = dcnt0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (rises != 5 || ncs0 !== 1'b1 || sclk0 !== 1'b0 || copi0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort: rises=%0d ncs=%b sclk=%b copi=%b done=%b busy=%b, required 5,1,0,0,0,0",
                     rises, ncs0, sclk0, copi0, done0, busy0);
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (dcnt0 != d0 || ncs0 !== 1'b1) begin
            errors++; $display("FAIL rstmid_nodone: %0d done pulses, ncs=%b, required 0 and 1", dcnt0 - d0, ncs0);
        end
        accept0(1'b1, 7'h03, 8'h0F);
        wait_idle0("rstmid_end");
        checks++;
        if (cap0 !== 16'h830F) begin errors++; $display("FAIL rstmid_frame: got %h, required 830f", cap0); end
        $display("rstmid: aborted after %0d rises, next frame=%h", rises, cap0);
    endtask

    task automatic test_clk_div1();
        int r1, d1, bad, done_obs;
        r1 = rise1; d1 = dcnt1; bad = 0; done_obs = -1;
        cmd_write1 = 1'b1; cmd_addr1 = 7'h7F; cmd_data1 = 8'h01; cmd_valid1 = 1'b1;
        step();
        cmd_valid1 = 1'b0;
        for (int n = 0; n < 41; n++) begin
            if (n < 32 && sclk1 !== ((n % 2 == 1) ? 1'b1 : 1'b0)) bad++;
            if (n == 5) begin
                cmd_write1 = 1'b1; cmd_addr1 = 7'h00; cmd_data1 = 8'hFF; cmd_valid1 = 1'b1;
            end
            if (n == 6) cmd_valid1 = 1'b0;
            if (done1 === 1'b1 && done_obs < 0) done_obs = n;
            if (n < 40) step();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL div1_sclk: %0d cycles off toggle pattern, required 0", bad); end
        checks++;
        if (done_obs != 33) begin errors++; $display("FAIL div1_done: done at T0+%0d, required T0+34", done_obs + 1); end
        checks++;
        if (cap1 !== 16'hFF01) begin errors++; $display("FAIL div1_frame: got %h, required ff01", cap1); end
        checks++;
        if (rise1 - r1 != 16 || dcnt1 - d1 != 1 || ncs1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL div1_ignored: rises=%0d dones=%0d ncs=%b busy=%b, required 16,1,1,0",
                     rise1 - r1, dcnt1 - d1, ncs1, busy1);
        end
        $display("div1: frame=%h done_at=T0+%0d", cap1, done_obs + 1);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid0 = 1'b0; cmd_write0 = 1'b0; cmd_addr0 = '0; cmd_data0 = '0;
        cmd_valid1 = 1'b0; cmd_write1 = 1'b0; cmd_addr1 = '0; cmd_data1 = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_clk_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
